vc_pop_scheduler: RTL and testbench
===================================

Name: vc_pop_scheduler

Overview:
- Read-side controller for the two virtual-channel FIFOs (VC0, VC1) in the transmission layer.
- Sequences initialisation and distributes the configured almost-empty/almost-full thresholds to both FIFOs.
- Arbitrates pops between VC0 and VC1 with weighted priority, and stalls on downstream backpressure.
- Returns the popped word with a valid strobe.

Parameters:
- DATA_WIDTH, 6, width of FIFO words.
- UMBRAL_WIDTH, 4, width of threshold values.
- WEIGHT_VC0, 3, maximum consecutive VC0 grants while VC1 is non-empty (range 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- init  input  1  high = run; low = (re)enter configuration.
- umbral_in  input  UMBRAL_WIDTH  threshold value captured during INIT.
- empty_VC0  input  1  VC0 FIFO empty flag.
- empty_VC1  input  1  VC1 FIFO empty flag.
- almost_full_D0  input  1  downstream destination 0 backpressure.
- almost_full_D1  input  1  downstream destination 1 backpressure.
- data_VC0  input  DATA_WIDTH  VC0 FIFO registered read data.
- data_VC1  input  DATA_WIDTH  VC1 FIFO registered read data.
- rd_enable_VC0  output  1  pop strobe to VC0.
- rd_enable_VC1  output  1  pop strobe to VC1.
- Umbral_VC0  output  UMBRAL_WIDTH  threshold driven to VC0 FIFO.
- Umbral_VC1  output  UMBRAL_WIDTH  threshold driven to VC1 FIFO.
- data_out  output  DATA_WIDTH  popped word.
- valid_out  output  1  data_out valid.
- state  output  2  current FSM state encoding.

Behaviour:
- Reset (reset=0, asynchronous): state=RESET.
  - rd_enable_VC0/VC1=0, Umbral_VC0/VC1=0, data_out=0, valid_out=0.
  - Internal registers cleared: weight counter=0, sel_d=0, pop_d=0.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- RESET -> INIT on the first clock edge with reset=1.
- INIT:
  - Umbral_VC0 and Umbral_VC1 load umbral_in every cycle.
  - No pops are issued.
  - Go to IDLE when init=1; the thresholds hold the last INIT-cycle value from then on.
- IDLE/ACTIVE:
  - init=0 -> INIT next edge; pops are suppressed combinationally in that same cycle.
  - Otherwise -> ACTIVE if a pop is issued this cycle, else -> IDLE.
- Pop eligibility (combinational, only in IDLE/ACTIVE with init=1):
  - stall = almost_full_D0 | almost_full_D1.
  - No pop while stall=1.
- Arbitration (4-bit weight counter wcnt):
  - VC0 wins if !empty_VC0 and (empty_VC1 or wcnt < WEIGHT_VC0).
  - Otherwise VC1 wins if !empty_VC1.
  - Otherwise no pop.
- Counter update:
  - VC0 grant: wcnt+1, saturating at WEIGHT_VC0.
  - VC1 grant: wcnt=0.
  - No grant: wcnt holds.
- At most one of rd_enable_VC0/rd_enable_VC1 is high in any cycle.
  - Both are derived from current flags so an empty FIFO is never popped.
  - Back-to-back pops of a 1-entry FIFO cannot occur because its empty flag updates on the pop edge.
- Return path:
  - A pop at cycle n registers pop_d=1 and sel_d (0=VC0, 1=VC1).
  - In cycle n+1: valid_out=pop_d, and data_out = sel_d ? data_VC1 : data_VC0 when pop_d=1, else 0.
  - Latency from pop to valid_out: 1 cycle.
  - Sustained throughput: one word per cycle.
- Reset asserted mid-burst: all outputs drop immediately; a word in flight (pop_d) is discarded.
- init=0 mid-burst: a word already popped still emits valid_out next cycle; no new pops are issued.
- Backpressure rising mid-burst: the in-flight word completes; pops resume the first cycle stall=0.

Decomposition:
- Shared package vc_pkg:
  - State encodings RESET/INIT/IDLE/ACTIVE.
  - Defaults DATA_WIDTH=6, UMBRAL_WIDTH=4.
  - Select encodings SEL_VC0=0, SEL_VC1=1.
- One natural sub-module, vc_weighted_arbiter: combinational grant logic plus the wcnt register.
- The top level holds the FSM, threshold registers and return-path mux.

Test Plan:
- Reset low 3 cycles, release with init=0, umbral_in=4'd3, then init=1 -> state RESET->INIT->IDLE; Umbral_VC0=Umbral_VC1=3; no rd_enable during INIT.
- Both FIFOs loaded with 8 words, WEIGHT_VC0=3, no stall -> grant order VC0,VC0,VC0,VC1 repeating; valid_out each cycle starting 1 cycle after the first pop; data_out matches the source FIFO order.
- VC1 only non-empty with 2 words -> two VC1 pops; rd_enable_VC1 drops the cycle empty_VC1 rises; state returns to IDLE.
- almost_full_D1=1 for 4 cycles during a burst -> zero pops in those cycles; in-flight word still valid once; resumes on release with wcnt preserved.
- init=0 after 2 pops of a burst -> no further pops; 2nd word still emitted; state INIT; new umbral_in=4'd5 captured; init=1 resumes with thresholds 5.
- Async reset asserted between clock edges while ACTIVE -> all outputs 0 immediately, no valid_out on the next edge.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared definitions for the VC0/VC1 read-side pop scheduler.
// State encodings, default widths, select encodings and the backpressure helper.
package vc_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam int DATA_WIDTH_DEF   = 6;
  localparam int UMBRAL_WIDTH_DEF = 4;

  localparam logic SEL_VC0 = 1'b0;
  localparam logic SEL_VC1 = 1'b1;

  function automatic logic stall_f(input logic af_d0, input logic af_d1);
    return af_d0 | af_d1;
  endfunction

endpackage

// File: rtl/vc_weighted_arbiter.sv
// Weighted VC0/VC1 grant logic: VC0 may take up to WEIGHT_VC0 consecutive
// grants while VC1 is waiting, then VC1 is served and the count restarts.
module vc_weighted_arbiter
  import vc_pkg::*;
#(
  parameter int WEIGHT_VC0 = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic empty_vc0_i,
  input  logic empty_vc1_i,
  output logic grant_vc0_o,
  output logic grant_vc1_o
);

  localparam logic [3:0] WMAX = 4'(WEIGHT_VC0);

  logic [3:0] wcnt_q;
  logic [3:0] wcnt_d;

  // Grant decision and weight counter next state.
  always_comb begin
    grant_vc0_o = 1'b0;
    grant_vc1_o = 1'b0;
    wcnt_d      = wcnt_q;
    if (en_i && !empty_vc0_i && (empty_vc1_i || (wcnt_q < WMAX))) begin
      grant_vc0_o = 1'b1;
      wcnt_d      = (wcnt_q >= WMAX) ? WMAX : (wcnt_q + 4'd1);
    end else if (en_i && !empty_vc1_i) begin
      grant_vc1_o = 1'b1;
      wcnt_d      = 4'd0;
    end else begin
      wcnt_d      = wcnt_q;
    end
  end

  // Weight counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= 4'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/vc_pop_scheduler.sv
// Read-side controller for the VC0/VC1 FIFOs: init sequencing, threshold
// distribution, weighted pop arbitration with backpressure and a 1-cycle return path.
module vc_pop_scheduler
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int UMBRAL_WIDTH = UMBRAL_WIDTH_DEF,
  parameter int WEIGHT_VC0   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_in,
  input  logic                    empty_VC0,
  input  logic                    empty_VC1,
  input  logic                    almost_full_D0,
  input  logic                    almost_full_D1,
  input  logic [DATA_WIDTH-1:0]   data_VC0,
  input  logic [DATA_WIDTH-1:0]   data_VC1,
  output logic                    rd_enable_VC0,
  output logic                    rd_enable_VC1,
  output logic [UMBRAL_WIDTH-1:0] Umbral_VC0,
  output logic [UMBRAL_WIDTH-1:0] Umbral_VC1,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic [1:0]              state
);

  state_e                  state_q, state_d;
  logic [UMBRAL_WIDTH-1:0] umbral_q, umbral_d;
  logic                    pop_q, pop_d;
  logic                    sel_q, sel_d;
  logic                    pop_en_s;
  logic                    grant_vc0_s, grant_vc1_s;

  // init=0 must kill pops in the same cycle, not one edge later.
  assign pop_en_s = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) && init &&
                    !stall_f(almost_full_D0, almost_full_D1);

  vc_weighted_arbiter #(
    .WEIGHT_VC0 (WEIGHT_VC0)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset),
    .en_i        (pop_en_s),
    .empty_vc0_i (empty_VC0),
    .empty_vc1_i (empty_VC1),
    .grant_vc0_o (grant_vc0_s),
    .grant_vc1_o (grant_vc1_s)
  );

  // FSM next state, threshold capture and return-path tags.
  always_comb begin
    state_d  = state_q;
    umbral_d = umbral_q;
    pop_d    = grant_vc0_s | grant_vc1_s;
    sel_d    = grant_vc1_s ? SEL_VC1 : SEL_VC0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        umbral_d = umbral_in;
        if (init) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (!init) begin
          state_d = ST_INIT;
        end else if (pop_d) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State, threshold and in-flight pop registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      umbral_q <= '0;
      pop_q    <= 1'b0;
      sel_q    <= SEL_VC0;
    end else begin
      state_q  <= state_d;
      umbral_q <= umbral_d;
      pop_q    <= pop_d;
      sel_q    <= sel_d;
    end
  end

  // The FIFO read data is registered, so the popped word arrives one cycle after the pop.
  always_comb begin
    data_out = '0;
    if (pop_q) begin
      data_out = (sel_q == SEL_VC1) ? data_VC1 : data_VC0;
    end else begin
      data_out = '0;
    end
  end

  assign rd_enable_VC0 = grant_vc0_s;
  assign rd_enable_VC1 = grant_vc1_s;
  assign Umbral_VC0    = umbral_q;
  assign Umbral_VC1    = umbral_q;
  assign valid_out     = pop_q;
  assign state         = state_q;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Directed bench for vc_pop_scheduler with two behavioural FIFOs whose read
// data is registered on the pop edge (VC0 words 1,2,3.. ; VC1 words 32,33,..).
module tb_vc_pop_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] umbral_in;
  logic       empty_VC0, empty_VC1;
  logic       almost_full_D0, almost_full_D1;
  logic [5:0] data_VC0 = 6'd0;
  logic [5:0] data_VC1 = 6'd0;
  logic       rd_enable_VC0, rd_enable_VC1;
  logic [3:0] Umbral_VC0, Umbral_VC1;
  logic [5:0] data_out;
  logic       valid_out;
  logic [1:0] state;

  int n_pass = 0;
  int n_chk  = 0;

  logic load_req = 1'b0;
  int   load0 = 0, load1 = 0;
  int   cnt0 = 0, cnt1 = 0, rp0 = 0, rp1 = 0;

  always #5 clk = ~clk;

  vc_pop_scheduler #(
    .DATA_WIDTH   (6),
    .UMBRAL_WIDTH (4),
    .WEIGHT_VC0   (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_in      (umbral_in),
    .empty_VC0      (empty_VC0),
    .empty_VC1      (empty_VC1),
    .almost_full_D0 (almost_full_D0),
    .almost_full_D1 (almost_full_D1),
    .data_VC0       (data_VC0),
    .data_VC1       (data_VC1),
    .rd_enable_VC0  (rd_enable_VC0),
    .rd_enable_VC1  (rd_enable_VC1),
    .Umbral_VC0     (Umbral_VC0),
    .Umbral_VC1     (Umbral_VC1),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .state          (state)
  );

  assign empty_VC0 = (cnt0 == 0);
  assign empty_VC1 = (cnt1 == 0);

  always @(posedge clk) begin
    if (load_req) begin
      cnt0 <= load0;
      cnt1 <= load1;
      rp0  <= 0;
      rp1  <= 0;
    end else begin
      if (rd_enable_VC0 && cnt0 > 0) begin
        data_VC0 <= 6'(1 + rp0);
        rp0      <= rp0 + 1;
        cnt0     <= cnt0 - 1;
      end
      if (rd_enable_VC1 && cnt1 > 0) begin
        data_VC1 <= 6'(32 + rp1);
        rp1      <= rp1 + 1;
        cnt1     <= cnt1 - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic r0, input logic r1, input logic v,
                         input logic [5:0] d, input logic [1:0] s, input logic [3:0] u);
    chk({tag, ".rd0"},   8'(rd_enable_VC0), 8'(r0));
    chk({tag, ".rd1"},   8'(rd_enable_VC1), 8'(r1));
    chk({tag, ".valid"}, 8'(valid_out),     8'(v));
    chk({tag, ".data"},  8'(data_out),      8'(d));
    chk({tag, ".state"}, 8'(state),         8'(s));
    chk({tag, ".umb0"},  8'(Umbral_VC0),    8'(u));
    chk({tag, ".umb1"},  8'(Umbral_VC1),    8'(u));
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later.
  task automatic step(input string tag, input logic ld, input logic st0, input logic st1,
                      input logic in_v, input logic [3:0] um,
                      input logic r0, input logic r1, input logic v,
                      input logic [5:0] d, input logic [1:0] s, input logic [3:0] u);
    @(negedge clk);
    load_req       = ld;
    almost_full_D0 = st0;
    almost_full_D1 = st1;
    init           = in_v;
    umbral_in      = um;
    #1;
    chk_all(tag, r0, r1, v, d, s, u);
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; umbral_in = 4'd0;
    almost_full_D0 = 1'b0; almost_full_D1 = 1'b0;
    load_req = 1'b1; load0 = 8; load1 = 8;
    #1;
    chk_all("rst", 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 4'd0);
    @(negedge clk); load_req = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1; umbral_in = 4'd3;
    #1;
    chk_all("rel", 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 4'd0);

    //   tag     ld    st0   st1   init  umb    rd0   rd1   vld   data    st    umb_exp
    step("iA",  1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 6'd0,  2'd1, 4'd0);
    step("iB",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 6'd0,  2'd1, 4'd3);
    step("c0",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 6'd0,  2'd2, 4'd3);
    step("c1",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd1,  2'd3, 4'd3);
    step("c2",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd2,  2'd3, 4'd3);
    step("c3",  1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 6'd3,  2'd3, 4'd3);
    step("c4",  1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 6'd0,  2'd2, 4'd3);
    step("c5",  1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 6'd0,  2'd2, 4'd3);
    step("c6",  1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 6'd0,  2'd2, 4'd3);
    step("c7",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 6'd0,  2'd2, 4'd3);
    step("c8",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd32, 2'd3, 4'd3);
    step("c9",  1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd4,  2'd3, 4'd3);
    step("c10", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd5,  2'd3, 4'd3);
    step("c11", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 6'd6,  2'd3, 4'd3);
    step("c12", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 6'd33, 2'd3, 4'd3);
    step("c13", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 6'd7,  2'd3, 4'd3);
    step("c14", 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 6'd0,  2'd1, 4'd3);
    step("c15", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 6'd0,  2'd1, 4'd5);
    step("c16", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 6'd0,  2'd2, 4'd5);
    step("c17", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 6'd8,  2'd3, 4'd5);
    load0 = 0; load1 = 2;
    step("c18", 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 6'd34, 2'd3, 4'd5);
    step("c19", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 6'd0,  2'd2, 4'd5);
    step("c20", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 6'd32, 2'd3, 4'd5);
    step("c21", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 6'd33, 2'd3, 4'd5);
    load0 = 8; load1 = 8;
    step("c22", 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 6'd0,  2'd2, 4'd5);
    step("c23", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 6'd0,  2'd2, 4'd5);
    step("c24", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 6'd1,  2'd3, 4'd5);

    // Asynchronous reset between edges while a pop is in flight.
    #2 reset = 1'b0;
    #1;
    chk_all("arst", 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 4'd0);
    @(negedge clk); #1;
    chk_all("arst_edge", 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 4'd0);
    reset = 1'b1; init = 1'b0;
    @(negedge clk); #1;
    chk_all("arst_rel", 1'b0, 1'b0, 1'b0, 6'd0, 2'd1, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
